// File: rtl/data_memory_mc_if.sv
// Request/response bus between the datapath and the multi-cycle data memory.
`default_nettype none

interface data_memory_mc_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [15:0] test_value;

  modport master (
    output req, we, size, unsigned_ld, addr, wdata,
    input  busy, done, rdata, err, test_value
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata,
    output busy, done, rdata, err, test_value
  );
endinterface

`default_nettype wire

// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressable data memory with byte/half/word access and req/done handshake.
// Optional misalignment trap: define DMEM_ALIGN_TRAP_EN.
`default_nettype none

module data_memory_mc #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_mc_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [31:0]   mem_q [DEPTH] = '{default: '0};

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [AW-1:0] w_idx;
  logic          w_is_byte, w_is_half;
  logic [1:0]    w_off;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_mask, w_wshift, w_merged;
  logic          w_fault;
  logic          w_complete;
  logic          w_mem_wr;
  logic          w_unused;

  assign w_unused  = ^bus.addr[31:AW+2];

  assign w_idx     = addr_q[AW+1:2];
  assign w_is_byte = (size_q == SZ_BYTE);
  assign w_is_half = (size_q == SZ_HALF);

  // Forcing the low offset bits to lane boundaries is what makes the untrapped
  // build silently align half/word accesses.
  assign w_off = w_is_byte ? addr_q[1:0] :
                 w_is_half ? {addr_q[1], 1'b0} : 2'b00;

  assign w_word = mem_q[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_word[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load = w_word;
    if (w_is_byte) begin
      w_load = uns_q ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (w_is_half) begin
      w_load = uns_q ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
    end
  end

  assign w_mask   = (w_is_byte ? 32'h0000_00FF :
                     w_is_half ? 32'h0000_FFFF : 32'hFFFF_FFFF) << {w_off, 3'b000};
  assign w_wshift = wdata_q << {w_off, 3'b000};
  assign w_merged = (w_word & ~w_mask) | (w_wshift & w_mask);

`ifdef DMEM_ALIGN_TRAP_EN
  assign w_fault = (w_is_half & addr_q[0]) |
                   (~w_is_half & ~w_is_byte & (addr_q[1:0] != 2'b00));
`else
  assign w_fault = 1'b0;
`endif

  assign w_complete = (state_q == S_BUSY) && (cnt_q == '0);
  assign w_mem_wr   = w_complete && we_q && !w_fault;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          uns_d   = bus.unsigned_ld;
          addr_d  = bus.addr[AW+1:0];
          wdata_d = bus.wdata;
          cnt_d   = LAT_M1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = w_fault;
          if (!we_q && !w_fault) begin
            rdata_d = w_load;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared by reset; a reset at the completion edge drops the store.
  always_ff @(posedge clk) begin
    if (w_mem_wr && !rst) begin
      mem_q[w_idx] <= w_merged;
    end
  end

  assign bus.busy       = (state_q == S_BUSY);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.test_value = mem_q[0][15:0];

endmodule

`default_nettype wire

// File: tb/tb_data_memory_mc.sv
// Directed self-checking bench for data_memory_mc (LATENCY=2 main DUT, LATENCY=1 throughput DUT).
`default_nettype none

module tb_data_memory_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  data_memory_mc_if bus_a ();
  data_memory_mc_if bus_b ();

  data_memory_mc #(.DEPTH(256), .LATENCY(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  data_memory_mc #(.DEPTH(16), .LATENCY(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one access on the main DUT; returns busy cycles, rdata/err in the done cycle.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int nbusy, output logic [31:0] rd, output logic e);
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.we = w; bus_a.size = sz; bus_a.unsigned_ld = u;
    bus_a.addr = a; bus_a.wdata = d;
    @(posedge clk); #1;
    bus_a.req = 1'b0;
    nbusy = 0;
    while (bus_a.busy === 1'b1 && nbusy < 20) begin
      nbusy++;
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, {31'b0, bus_a.done}, 32'd1);
    rd = bus_a.rdata;
    e  = bus_a.err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          nb;
    logic [31:0] rd;
    logic        e;
    logic [31:0] rd_after_mis;

    bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.size = 2'b00; bus_a.unsigned_ld = 1'b0;
    bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.size = 2'b10; bus_b.unsigned_ld = 1'b0;
    bus_b.addr = '0; bus_b.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'b0, bus_a.busy}, 32'd0);
    chk("rst_done",  {31'b0, bus_a.done}, 32'd0);
    chk("rst_err",   {31'b0, bus_a.err},  32'd0);
    chk("rst_rdata", bus_a.rdata, 32'd0);
    chk("rst_tv",    {16'b0, bus_a.test_value}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store then unsigned byte load of the top lane
    access("st_w0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678, nb, rd, e);
    chk("st_w0_busy", nb, 32'd2);
    chk("st_w0_tv",   {16'b0, bus_a.test_value}, 32'h0000_5678);
    @(posedge clk); #1;
    chk("done_pulse_end", {31'b0, bus_a.done}, 32'd0);
    access("ld_bu3", 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, nb, rd, e);
    chk("ld_bu3", rd, 32'h0000_0012);

    // Byte store: only lane 1 changes even with dirty upper wdata bits
    access("st_b1", 1'b1, 2'b00, 1'b0, 32'h1, 32'hAAAA_AA80, nb, rd, e);
    access("ld_bs1", 1'b0, 2'b00, 1'b0, 32'h1, 32'h0, nb, rd, e);
    chk("ld_bs1", rd, 32'hFFFF_FF80);
    access("ld_bu1", 1'b0, 2'b00, 1'b1, 32'h1, 32'h0, nb, rd, e);
    chk("ld_bu1", rd, 32'h0000_0080);
    access("ld_w0", 1'b0, 2'b10, 1'b1, 32'h0, 32'h0, nb, rd, e);
    chk("ld_w0", rd, 32'h1234_8078);

    // Half store at upper lane of word 1
    access("st_h6", 1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_BEEF, nb, rd, e);
    access("ld_hs6", 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, nb, rd, e);
    chk("ld_hs6", rd, 32'hFFFF_BEEF);
    access("ld_hu6", 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, nb, rd, e);
    chk("ld_hu6", rd, 32'h0000_BEEF);
    access("ld_w4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, nb, rd, e);
    chk("ld_w4", rd, 32'hBEEF_0000);

    // Misaligned word load
    access("ld_mis2", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, nb, rd, e);
`ifdef DMEM_ALIGN_TRAP_EN
    rd_after_mis = 32'hBEEF_0000;
    chk("mis2_err", {31'b0, e}, 32'd1);
`else
    rd_after_mis = 32'h1234_8078;
    chk("mis2_err", {31'b0, e}, 32'd0);
`endif
    chk("mis2_rdata", rd, rd_after_mis);
    chk("mis2_busy", nb, 32'd2);

    // Store with inputs scrambled while busy; rdata must hold through a store
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.size = 2'b10; bus_a.unsigned_ld = 1'b0;
    bus_a.addr = 32'h8; bus_a.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus_a.we = 1'b0; bus_a.size = 2'b00; bus_a.addr = 32'h0; bus_a.wdata = 32'h0;
    @(posedge clk); #1;
    chk("ign_busy_mid", {31'b0, bus_a.busy}, 32'd1);
    bus_a.req = 1'b0;
    @(posedge clk); #1;
    chk("ign_done",  {31'b0, bus_a.done}, 32'd1);
    chk("ign_busy0", {31'b0, bus_a.busy}, 32'd0);
    chk("st_hold_rdata", bus_a.rdata, rd_after_mis);
    @(posedge clk); #1;
    chk("ign_no_reaccept", {31'b0, bus_a.busy}, 32'd0);
    chk("ign_tv", {16'b0, bus_a.test_value}, 32'h0000_8078);
    access("ld_w8", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, nb, rd, e);
    chk("ld_w8", rd, 32'hCAFE_F00D);

    // Back-to-back throughput on the LATENCY=1 DUT with req held high
    @(negedge clk);
    bus_b.req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("thr_busy_%0d", i), {31'b0, bus_b.busy}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("thr_done_%0d", i), {31'b0, bus_b.done}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    bus_b.req = 1'b0;

    // Reset right after a store accept: store must be dropped
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.size = 2'b10; bus_a.addr = 32'h0;
    bus_a.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_a.req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_busy",  {31'b0, bus_a.busy}, 32'd0);
    chk("rstmid_done",  {31'b0, bus_a.done}, 32'd0);
    chk("rstmid_rdata", bus_a.rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_tv", {16'b0, bus_a.test_value}, 32'h0000_8078);
    access("ld_w0_post", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, nb, rd, e);
    chk("ld_w0_post", rd, 32'h1234_8078);

    // Address wrap: 0x400 aliases word 0 with DEPTH=256
    access("st_wrap", 1'b1, 2'b10, 1'b0, 32'h400, 32'h0000_A5A5, nb, rd, e);
    chk("wrap_tv", {16'b0, bus_a.test_value}, 32'h0000_A5A5);
    access("ld_wrap", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, nb, rd, e);
    chk("ld_wrap", rd, 32'h0000_A5A5);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
